// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : intersection_phase_scheduler
// Brief    : Road A / road B / pedestrian phase sequencer with a shared timer.
// Revision : 1.0
// ============================================================================
module intersection_phase_scheduler #(
    parameter int T_MIN_GREEN = 5000,
    parameter int T_MAX_GREEN = 30000,
    parameter int T_YELLOW    = 5000,
    parameter int T_ALL_RED   = 1000,
    parameter int T_WALK      = 10000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_b,
    input  logic       ped_req,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_ALL_RED = 3'd0,
        S_A_GRN   = 3'd1,
        S_A_YEL   = 3'd2,
        S_B_GRN   = 3'd3,
        S_B_YEL   = 3'd4,
        S_WALK    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_WALK = 2'd2
    } sel_t;

    localparam logic [CNT_W-1:0] c_min_green_last = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_max_green_last = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] c_yellow_last    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] c_all_red_last   = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] c_walk_last      = CNT_W'(T_WALK - 1);

    localparam logic [2:0] c_red    = 3'b100;
    localparam logic [2:0] c_yellow = 3'b010;
    localparam logic [2:0] c_green  = 3'b001;

    state_t           r_state;
    state_t           w_state_nxt;
    sel_t             r_next_sel;
    sel_t             w_next_sel;
    logic [CNT_W-1:0] r_timer;
    logic             r_b_pending;
    logic             r_ped_pending;
    logic             w_b_dem;
    logic             w_ped_dem;
    logic             w_enter_b;
    logic             w_enter_walk;
    logic [2:0]       r_light_a;
    logic [2:0]       r_light_b;
    logic             r_walk;
    logic             r_ped_ack;

    // Demand includes this cycle's input so a request can end a phase at once.
    assign w_b_dem      = r_b_pending   | (req_b   & (r_state != S_B_GRN));
    assign w_ped_dem    = r_ped_pending | (ped_req & (r_state != S_WALK));
    assign w_enter_b    = (w_state_nxt == S_B_GRN) && (r_state != S_B_GRN);
    assign w_enter_walk = (w_state_nxt == S_WALK)  && (r_state != S_WALK);

    always_comb begin
        w_state_nxt = r_state;
        w_next_sel  = r_next_sel;
        case (r_state)
            S_ALL_RED: begin
                if (r_timer == c_all_red_last) begin
                    case (r_next_sel)
                        SEL_B:    w_state_nxt = S_B_GRN;
                        SEL_WALK: w_state_nxt = S_WALK;
                        default:  w_state_nxt = S_A_GRN;
                    endcase
                end
            end
            S_A_GRN: begin
                if ((r_timer >= c_min_green_last) && (w_b_dem || w_ped_dem))
                    w_state_nxt = S_A_YEL;
            end
            S_A_YEL: begin
                if (r_timer == c_yellow_last) begin
                    w_state_nxt = S_ALL_RED;
                    w_next_sel  = w_b_dem ? SEL_B : SEL_WALK;
                end
            end
            S_B_GRN: begin
                if (((r_timer >= c_min_green_last) && (!req_b || w_ped_dem)) ||
                    (r_timer == c_max_green_last))
                    w_state_nxt = S_B_YEL;
            end
            S_B_YEL: begin
                if (r_timer == c_yellow_last) begin
                    w_state_nxt = S_ALL_RED;
                    w_next_sel  = w_ped_dem ? SEL_WALK : SEL_A;
                end
            end
            S_WALK: begin
                if (r_timer == c_walk_last) begin
                    w_state_nxt = S_ALL_RED;
                    w_next_sel  = SEL_A;
                end
            end
            default: begin
                w_state_nxt = S_ALL_RED;
                w_next_sel  = SEL_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_ALL_RED;
            r_next_sel    <= SEL_A;
            r_timer       <= '0;
            r_b_pending   <= 1'b0;
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_next_sel <= w_next_sel;
            if (w_state_nxt != r_state)
                r_timer <= '0;
            else if (r_timer != '1)
                r_timer <= r_timer + 1'b1;
            r_b_pending   <= w_enter_b    ? 1'b0 : w_b_dem;
            r_ped_pending <= w_enter_walk ? 1'b0 : w_ped_dem;
            r_ped_ack     <= w_enter_walk;
        end
    end

    // Lamp drive is decoded from the current phase and therefore lags it by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_light_a <= 3'b111;
            r_light_b <= 3'b111;
            r_walk    <= 1'b0;
        end else begin
            r_light_a <= c_red;
            r_light_b <= c_red;
            r_walk    <= 1'b0;
            case (r_state)
                S_A_GRN: r_light_a <= c_green;
                S_A_YEL: r_light_a <= c_yellow;
                S_B_GRN: r_light_b <= c_green;
                S_B_YEL: r_light_b <= c_yellow;
                S_WALK:  r_walk    <= 1'b1;
                default: ;
            endcase
        end
    end

    assign phase   = r_state;
    assign light_a = r_light_a;
    assign light_b = r_light_b;
    assign walk    = r_walk;
    assign ped_ack = r_ped_ack;

endmodule
`default_nettype wire
